load_store_unit: RTL and testbench

Memory-stage load/store unit that sits directly downstream of the ALU. It takes the ALU result as the effective address, plus rs2 data and the access size, and runs one data-memory transaction per request over a valid/ready bus. It returns sign- or zero-extended load data, or store completion, together with an error code. While busy it holds the pipeline through `stall`.

---
 rtl/load_store_unit.sv | 206 ++++++++++++++++++++
 tb/tb_load_store_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one data-memory transaction per request over a
// valid/ready bus, with lane steering, load extension, and error reporting.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_err,
  output logic        stall
);

  // Counter is at least 8 bits wide, wider if the timeout needs it.
  localparam int CLOG_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW     = (CLOG_W > 8) ? CLOG_W : 8;
  localparam logic [CW-1:0] TO_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_SIZE     = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_RESP = 2'b10
  } state_t;

  state_t         state_q;
  logic           mem_valid_q;
  logic           mem_we_q;
  logic [31:0]    mem_addr_q;
  logic [3:0]     mem_wstrb_q;
  logic [31:0]    mem_wdata_q;
  logic [1:0]     size_q;
  logic           unsigned_q;
  logic [1:0]     off_q;
  logic [CW-1:0]  cnt_q;
  logic           resp_valid_q;
  logic [31:0]    resp_rdata_q;
  logic [1:0]     resp_err_q;

  logic           size_rsvd;
  logic           misaligned;
  logic [3:0]     wstrb_d;
  logic [31:0]    wdata_d;
  logic [31:0]    load_data_d;
  logic [7:0]     byte_sel;
  logic [15:0]    half_sel;
  logic           timeout_hit;

  // Request legality: reserved size is checked ahead of alignment.
  always_comb begin
    size_rsvd  = (req_size == 2'b11);
    misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                 ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
  end

  // Store lane steering: strobes from size/offset, data replicated across lanes.
  always_comb begin
    wstrb_d = 4'b0000;
    wdata_d = 32'h0;
    if (req_we) begin
      case (req_size)
        2'b00: begin
          wstrb_d = 4'b0001 << req_addr[1:0];
          wdata_d = {4{req_wdata[7:0]}};
        end
        2'b01: begin
          wstrb_d = req_addr[1] ? 4'b1100 : 4'b0011;
          wdata_d = {2{req_wdata[15:0]}};
        end
        2'b10: begin
          wstrb_d = 4'b1111;
          wdata_d = req_wdata;
        end
        default: begin
          wstrb_d = 4'b0000;
          wdata_d = 32'h0;
        end
      endcase
    end
  end

  // Load extraction: pick the addressed lane and sign- or zero-extend it.
  always_comb begin
    case (off_q)
      2'b00:   byte_sel = mem_rdata[7:0];
      2'b01:   byte_sel = mem_rdata[15:8];
      2'b10:   byte_sel = mem_rdata[23:16];
      default: byte_sel = mem_rdata[31:24];
    endcase
    half_sel = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      2'b00:   load_data_d = {{24{byte_sel[7]  & ~unsigned_q}}, byte_sel};
      2'b01:   load_data_d = {{16{half_sel[15] & ~unsigned_q}}, half_sel};
      default: load_data_d = mem_rdata;
    endcase
  end

  // Last permitted wait cycle; a zero timeout never fires.
  always_comb begin
    timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);
  end

  // Transaction FSM with all bus and response outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      mem_valid_q  <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'h0;
      mem_wstrb_q  <= 4'b0000;
      mem_wdata_q  <= 32'h0;
      size_q       <= 2'b00;
      unsigned_q   <= 1'b0;
      off_q        <= 2'b00;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= ERR_OK;
    end else begin
      case (state_q)
        S_IDLE: begin
          resp_valid_q <= 1'b0;
          resp_rdata_q <= 32'h0;
          resp_err_q   <= ERR_OK;
          if (req_valid) begin
            size_q     <= req_size;
            unsigned_q <= req_unsigned;
            off_q      <= req_addr[1:0];
            if (size_rsvd || misaligned) begin
              // Illegal request: answer directly, never touch the bus.
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= size_rsvd ? ERR_SIZE : ERR_MISALIGN;
            end else begin
              state_q     <= S_REQ;
              mem_valid_q <= 1'b1;
              mem_we_q    <= req_we;
              mem_addr_q  <= {req_addr[31:2], 2'b00};
              mem_wstrb_q <= wstrb_d;
              mem_wdata_q <= wdata_d;
              cnt_q       <= '0;
            end
          end
        end
        S_REQ: begin
          if (mem_ready) begin
            // A ready on the last wait cycle still completes normally.
            state_q      <= S_RESP;
            mem_valid_q  <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= mem_we_q ? 32'h0 : load_data_d;
            resp_err_q   <= ERR_OK;
          end else if (timeout_hit) begin
            state_q      <= S_RESP;
            mem_valid_q  <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= ERR_TIMEOUT;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_RESP: begin
          state_q      <= S_IDLE;
          resp_valid_q <= 1'b0;
          resp_rdata_q <= 32'h0;
          resp_err_q   <= ERR_OK;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign stall      = (state_q != S_IDLE);
  assign mem_valid  = mem_valid_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wstrb  = mem_wstrb_q;
  assign mem_wdata  = mem_wdata_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: the driver queues expected bus and
// response records, independent monitors pop and compare them.
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic        stall;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .stall(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rdata;
    logic [1:0]  err;
  } resp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } bus_t;

  resp_t resp_q[$];
  bus_t  bus_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Response monitor: every resp_valid pulse must match the oldest expectation.
  always @(negedge clk) begin : resp_mon
    resp_t e;
    if (rst_n && resp_valid) begin
      if (resp_q.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        e = resp_q.pop_front();
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_err", {30'b0, resp_err}, {30'b0, e.err});
      end
    end
  end

  // Bus monitor: pop on the rising mem_valid, then hold every cycle it stays up.
  logic mv_prev = 1'b0;
  logic have_cur = 1'b0;
  bus_t cur;
  always @(negedge clk) begin : bus_mon
    if (mem_valid && !mv_prev) begin
      if (bus_q.size() == 0) begin
        chk("unexpected_bus", 32'd1, 32'd0);
        have_cur = 1'b0;
      end else begin
        cur = bus_q.pop_front();
        have_cur = 1'b1;
      end
    end
    if (mem_valid && have_cur) begin
      chk("mem_addr", mem_addr, cur.addr);
      chk("mem_we", {31'b0, mem_we}, {31'b0, cur.we});
      chk("mem_wstrb", {28'b0, mem_wstrb}, {28'b0, cur.wstrb});
      chk("mem_wdata", mem_wdata, cur.wdata);
    end
    mv_prev = mem_valid;
  end

  // One request plus memory model; w<0 means memory never answers.
  task automatic run(input string tag, input logic we, input logic [1:0] size,
                     input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                     input int w, input logic [31:0] rdata,
                     input logic [31:0] exp_rdata, input logic [1:0] exp_err,
                     input logic bus, input logic [31:0] exp_addr,
                     input logic [3:0] exp_wstrb, input logic [31:0] exp_wdata,
                     input int exp_lat, input int exp_mv);
    int k = 0;
    int waits = 0;
    int mv = 0;
    bit seen = 0;
    resp_t r;
    bus_t b;
    r.rdata = exp_rdata; r.err = exp_err;
    resp_q.push_back(r);
    if (bus) begin
      b.addr = exp_addr; b.we = we; b.wstrb = exp_wstrb; b.wdata = exp_wdata;
      bus_q.push_back(b);
    end
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    while (!seen && k < 40) begin
      @(negedge clk);
      k++;
      if (resp_valid) seen = 1;
      if (mem_valid) begin
        mv++;
        if (w >= 0 && waits == w) begin
          mem_ready = 1'b1;
          mem_rdata = rdata;
        end else begin
          mem_ready = 1'b0;
          mem_rdata = $urandom;
          waits++;
        end
      end else begin
        mem_ready = 1'b0;
      end
    end
    chk({tag, "_latency"}, seen ? k : 999, exp_lat);
    chk({tag, "_mem_valid_cycles"}, mv, exp_mv);
    @(negedge clk);
    chk({tag, "_idle_ready"}, {29'b0, req_ready, stall, resp_valid}, 32'b100);
    chk({tag, "_idle_resp"}, resp_rdata | {30'b0, resp_err}, 32'h0);
    $display("txn %s: latency=%0d mem_valid_cycles=%0d", tag, seen ? k : 999, mv);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    mem_ready = 1'b0; mem_rdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_mem", {mem_valid, mem_we, mem_wstrb} | mem_addr | mem_wdata, 32'h0);
    chk("rst_resp", {29'b0, resp_valid, resp_err} | resp_rdata, 32'h0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);

    //  tag          we  size   uns   addr          wdata        w   rdata         exp_rdata     err    bus  exp_addr      wstrb    exp_wdata     lat mv
    run("lw_100",    0, 2'b10, 0, 32'h0000_0100, 32'h0,       0, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 1, 32'h0000_0100, 4'b0000, 32'h0,        2, 1);
    run("lb_103",    0, 2'b00, 0, 32'h0000_0103, 32'h0,       0, 32'h8012_3456, 32'hFFFF_FF80, 2'b00, 1, 32'h0000_0100, 4'b0000, 32'h0,       2, 1);
    run("lbu_103",   0, 2'b00, 1, 32'h0000_0103, 32'h0,       1, 32'h8012_3456, 32'h0000_0080, 2'b00, 1, 32'h0000_0100, 4'b0000, 32'h0,       3, 2);
    run("lb_101",    0, 2'b00, 0, 32'h0000_0101, 32'h0,       0, 32'h0000_7F00, 32'h0000_007F, 2'b00, 1, 32'h0000_0100, 4'b0000, 32'h0,       2, 1);
    run("lb_102",    0, 2'b00, 0, 32'h0000_0102, 32'h0,       0, 32'h00FE_0000, 32'hFFFF_FFFE, 2'b00, 1, 32'h0000_0100, 4'b0000, 32'h0,       2, 1);
    run("lh_102",    0, 2'b01, 0, 32'h0000_0102, 32'h0,       0, 32'h8001_1234, 32'hFFFF_8001, 2'b00, 1, 32'h0000_0100, 4'b0000, 32'h0,       2, 1);
    run("lhu_100",   0, 2'b01, 1, 32'h0000_0100, 32'h0,       0, 32'h1234_F00D, 32'h0000_F00D, 2'b00, 1, 32'h0000_0100, 4'b0000, 32'h0,       2, 1);
    run("sh_202",    1, 2'b01, 0, 32'h0000_0202, 32'h1234ABCD, 2, 32'hFFFF_FFFF, 32'h0,        2'b00, 1, 32'h0000_0200, 4'b1100, 32'hABCDABCD, 4, 3);
    run("sb_301",    1, 2'b00, 0, 32'h0000_0301, 32'h0000_00A5, 0, 32'hFFFF_FFFF, 32'h0,       2'b00, 1, 32'h0000_0300, 4'b0010, 32'hA5A5A5A5, 2, 1);
    run("sw_400",    1, 2'b10, 0, 32'h0000_0400, 32'hCAFEF00D, 0, 32'hFFFF_FFFF, 32'h0,        2'b00, 1, 32'h0000_0400, 4'b1111, 32'hCAFEF00D, 2, 1);
    run("lw_mis",    0, 2'b10, 0, 32'h0000_0101, 32'h0,       0, 32'h0,        32'h0,        2'b01, 0, 32'h0,        4'b0000, 32'h0,        1, 0);
    run("rsvd_101",  0, 2'b11, 0, 32'h0000_0101, 32'h0,       0, 32'h0,        32'h0,        2'b11, 0, 32'h0,        4'b0000, 32'h0,        1, 0);
    run("sh_mis",    1, 2'b01, 0, 32'h0000_0103, 32'h5555,    0, 32'h0,        32'h0,        2'b01, 0, 32'h0,        4'b0000, 32'h0,        1, 0);
    run("lw_tmo",    0, 2'b10, 0, 32'h0000_0500, 32'h0,      -1, 32'h0,        32'h0,        2'b10, 1, 32'h0000_0500, 4'b0000, 32'h0,        5, 4);
    run("lbu_last",  0, 2'b00, 1, 32'h0000_0500, 32'h0,       3, 32'h0000_00FF, 32'h0000_00FF, 2'b00, 1, 32'h0000_0500, 4'b0000, 32'h0,       5, 4);

    // Reset pulsed in the middle of a bus wait: no response may follow.
    begin : mid_reset
      bus_t b;
      int late_resp = 0;
      b.addr = 32'h0000_0600; b.we = 1'b0; b.wstrb = 4'b0000; b.wdata = 32'h0;
      bus_q.push_back(b);
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
      req_addr = 32'h0000_0600; req_wdata = 32'h0;
      @(posedge clk);
      #1 req_valid = 1'b0;
      mem_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("midrst_busy", {30'b0, mem_valid, stall}, 32'b11);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_mem_valid", {31'b0, mem_valid}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) begin
        @(negedge clk);
        if (resp_valid) late_resp++;
      end
      chk("midrst_no_resp", late_resp, 0);
      chk("midrst_req_ready", {31'b0, req_ready}, 32'd1);
      $display("txn midrst: late_resp=%0d", late_resp);
    end

    repeat (2) @(negedge clk);
    chk("resp_q_drained", resp_q.size(), 0);
    chk("bus_q_drained", bus_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
